// File: rtl/display_box_overlay.sv
// Multi-box rectangle outline overlay on a pixel stream, fixed latency of 2 cycles.
// Optional interior 50% blend fill enabled by defining DISPLAY_BOX_OVERLAY_FILL_EN.
module display_box_overlay #(
  parameter int NUM_BOX = 4,
  parameter int CW      = 12,
  parameter int DW      = 24,
  parameter int LINE_W  = 2,
  parameter bit VS_POL  = 1'b1
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic [DW-1:0] i_rgb,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  input  logic [CW-1:0] i_hcount,
  input  logic [CW-1:0] i_vcount,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_idx,
  input  logic          cfg_en,
  input  logic [CW-1:0] cfg_hl,
  input  logic [CW-1:0] cfg_hr,
  input  logic [CW-1:0] cfg_vl,
  input  logic [CW-1:0] cfg_vr,
  input  logic [DW-1:0] cfg_color,
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
  input  logic          cfg_fill,
`endif
  output logic [DW-1:0] o_rgb,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [7:0]    o_frame
);

  typedef struct packed {
    logic          en;
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
    logic          fill;
`endif
    logic [CW-1:0] hl;
    logic [CW-1:0] hr;
    logic [CW-1:0] vl;
    logic [CW-1:0] vr;
    logic [DW-1:0] color;
  } box_t;

  localparam logic [CW:0] EXT_W  = (CW+1)'(LINE_W - 1);
  localparam logic [CW:0] CO_MAX = {1'b0, {CW{1'b1}}};

  function automatic logic [CW:0] ext(input logic [CW-1:0] c);
    return {1'b0, c};
  endfunction

  // Outer edge bounds widened by the line thickness, clamped to the coordinate range.
  function automatic logic [CW:0] lo_bound(input logic [CW-1:0] c);
    if (ext(c) >= EXT_W) return ext(c) - EXT_W;
    return '0;
  endfunction

  function automatic logic [CW:0] hi_bound(input logic [CW-1:0] c);
    logic [CW:0] s;
    s = ext(c) + EXT_W;
    if (s > CO_MAX) return CO_MAX;
    return s;
  endfunction

  function automatic logic in_rng(input logic [CW:0] x, lo, hi);
    return (lo <= x) && (x <= hi);
  endfunction

  function automatic logic box_valid(input box_t b);
    return b.en && (b.hl <= b.hr) && (b.vl <= b.vr);
  endfunction

  function automatic logic edge_hit(input box_t b, input logic [CW:0] h, v);
    logic vert, horz;
    vert = in_rng(v, ext(b.vl), ext(b.vr)) &&
           (in_rng(h, lo_bound(b.hl), ext(b.hl)) || in_rng(h, ext(b.hr), hi_bound(b.hr)));
    horz = in_rng(h, ext(b.hl), ext(b.hr)) &&
           (in_rng(v, lo_bound(b.vl), ext(b.vl)) || in_rng(v, ext(b.vr), hi_bound(b.vr)));
    return box_valid(b) && (vert || horz);
  endfunction

`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
  function automatic logic fill_hit(input box_t b, input logic [CW:0] h, v);
    return box_valid(b) && b.fill && (ext(b.hl) < h) && (h < ext(b.hr)) &&
           (ext(b.vl) < v) && (v < ext(b.vr));
  endfunction

  function automatic logic [DW-1:0] blend(input logic [DW-1:0] a, input logic [DW-1:0] c);
    logic [DW-1:0] o;
    o = '0;
    for (int k = 0; k < DW/8; k++)
      o[k*8 +: 8] = {1'b0, a[k*8+1 +: 7]} + {1'b0, c[k*8+1 +: 7]};
    return o;
  endfunction
`endif

  box_t sh_q  [NUM_BOX];
  box_t sh_d  [NUM_BOX];
  box_t act_q [NUM_BOX];
  box_t act_d [NUM_BOX];
  box_t wr_box;

  logic       vsa_q;
  logic       commit;
  logic [7:0] frame_q, frame_d;

  logic [NUM_BOX-1:0] hit_d, hit_p1_q;
  logic [NUM_BOX-1:0] fill_d, fill_p1_q;
  logic [DW-1:0]      rgb_p1_q, rgb_p2_d, rgb_p2_q;
  logic               hs_p1_q, vs_p1_q, de_p1_q;
  logic               hs_p2_q, vs_p2_q, de_p2_q;

  always_comb begin
    wr_box       = '0;
    wr_box.en    = cfg_en;
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
    wr_box.fill  = cfg_fill;
`endif
    wr_box.hl    = cfg_hl;
    wr_box.hr    = cfg_hr;
    wr_box.vl    = cfg_vl;
    wr_box.vr    = cfg_vr;
    wr_box.color = cfg_color;
  end

  // Commit: shadow set becomes active on the cycle vsync enters its active level.
  always_comb begin
    commit  = (i_vsync == VS_POL) && !vsa_q;
    frame_d = frame_q + 8'(commit);
    sh_d    = sh_q;
    act_d   = act_q;
    if (commit) act_d = sh_q;
    for (int i = 0; i < NUM_BOX; i++)
      if (cfg_we && (cfg_idx == 3'(i))) sh_d[i] = wr_box;
  end

  always_comb begin
    hit_d  = '0;
    fill_d = '0;
    for (int i = 0; i < NUM_BOX; i++) begin
      hit_d[i] = edge_hit(act_q[i], ext(i_hcount), ext(i_vcount));
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
      fill_d[i] = fill_hit(act_q[i], ext(i_hcount), ext(i_vcount));
`endif
    end
  end

  // Descending scans so the lowest index is applied last; edges override any fill.
  always_comb begin
    rgb_p2_d = rgb_p1_q;
    if (de_p1_q) begin
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
      for (int i = NUM_BOX-1; i >= 0; i--)
        if (fill_p1_q[i]) rgb_p2_d = blend(rgb_p1_q, act_q[i].color);
`endif
      for (int i = NUM_BOX-1; i >= 0; i--)
        if (hit_p1_q[i]) rgb_p2_d = act_q[i].color;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BOX; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
      vsa_q     <= 1'b0;
      frame_q   <= '0;
      hit_p1_q  <= '0;
      fill_p1_q <= '0;
      rgb_p1_q  <= '0;
      hs_p1_q   <= 1'b0;
      vs_p1_q   <= 1'b0;
      de_p1_q   <= 1'b0;
      rgb_p2_q  <= '0;
      hs_p2_q   <= 1'b0;
      vs_p2_q   <= 1'b0;
      de_p2_q   <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      act_q     <= act_d;
      vsa_q     <= (i_vsync == VS_POL);
      frame_q   <= frame_d;
      // stage 1: hit vectors and delayed input
      hit_p1_q  <= hit_d;
      fill_p1_q <= fill_d;
      rgb_p1_q  <= i_rgb;
      hs_p1_q   <= i_hsync;
      vs_p1_q   <= i_vsync;
      de_p1_q   <= i_de;
      // stage 2: priority-muxed colour
      rgb_p2_q  <= rgb_p2_d;
      hs_p2_q   <= hs_p1_q;
      vs_p2_q   <= vs_p1_q;
      de_p2_q   <= de_p1_q;
    end
  end

  assign o_rgb   = rgb_p2_q;
  assign o_hsync = hs_p2_q;
  assign o_vsync = vs_p2_q;
  assign o_de    = de_p2_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_display_box_overlay.sv
// Directed bench for display_box_overlay: default instance (LINE_W=2) plus a LINE_W=4
// instance sharing the same stimulus for the clamp/saturation corner.
module tb_display_box_overlay;

  logic        pixelclk = 1'b0;
  logic        reset;
  logic [23:0] i_rgb;
  logic        i_hsync, i_vsync, i_de;
  logic [11:0] i_hcount, i_vcount;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_en;
  logic [11:0] cfg_hl, cfg_hr, cfg_vl, cfg_vr;
  logic [23:0] cfg_color;
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
  logic        cfg_fill;
`endif
  logic [23:0] o_rgb, o_rgb4;
  logic        o_hsync, o_vsync, o_de, o_hsync4, o_vsync4, o_de4;
  logic [7:0]  o_frame, o_frame4;

  int checks = 0;
  int errors = 0;
  int exp_frame = 0;

  always #5 pixelclk = ~pixelclk;

  display_box_overlay #(.NUM_BOX(4), .CW(12), .DW(24), .LINE_W(2), .VS_POL(1'b1)) u_dut (
    .pixelclk(pixelclk), .reset(reset), .i_rgb(i_rgb), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_de(i_de), .i_hcount(i_hcount), .i_vcount(i_vcount), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_hl(cfg_hl), .cfg_hr(cfg_hr), .cfg_vl(cfg_vl), .cfg_vr(cfg_vr),
    .cfg_color(cfg_color),
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
    .cfg_fill(cfg_fill),
`endif
    .o_rgb(o_rgb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_frame(o_frame));

  display_box_overlay #(.NUM_BOX(4), .CW(12), .DW(24), .LINE_W(4), .VS_POL(1'b1)) u_dut4 (
    .pixelclk(pixelclk), .reset(reset), .i_rgb(i_rgb), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_de(i_de), .i_hcount(i_hcount), .i_vcount(i_vcount), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_hl(cfg_hl), .cfg_hr(cfg_hr), .cfg_vl(cfg_vl), .cfg_vr(cfg_vr),
    .cfg_color(cfg_color),
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
    .cfg_fill(cfg_fill),
`endif
    .o_rgb(o_rgb4), .o_hsync(o_hsync4), .o_vsync(o_vsync4), .o_de(o_de4), .o_frame(o_frame4));

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic [23:0] rgb;
    logic        de;
    logic [23:0] exp;
  } vec_t;

  vec_t t1 [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cfg_set(input logic [2:0] idx, input logic en, input logic [11:0] hl, hr, vl, vr,
                         input logic [23:0] col, input logic fl);
    cfg_idx = idx; cfg_en = en; cfg_hl = hl; cfg_hr = hr; cfg_vl = vl; cfg_vr = vr;
    cfg_color = col;
`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
    cfg_fill = fl;
`else
    if (fl) cfg_en = en;
`endif
  endtask

  task automatic cfg_wr(input logic [2:0] idx, input logic en, input logic [11:0] hl, hr, vl, vr,
                        input logic [23:0] col, input logic fl);
    cfg_set(idx, en, hl, hr, vl, vr, col, fl);
    cfg_we = 1'b1;
    @(posedge pixelclk); #1;
    cfg_we = 1'b0;
  endtask

  // Vsync pulse of two cycles; any cfg_we already raised lands in the commit cycle only.
  task automatic vs();
    i_vsync = 1'b1; i_de = 1'b0;
    @(posedge pixelclk); #1;
    cfg_we = 1'b0;
    @(posedge pixelclk); #1;
    chk("vsync_delay", {31'b0, o_vsync}, 32'd1);
    exp_frame++;
    chk("frame_count", {24'b0, o_frame}, 32'(exp_frame));
    i_vsync = 1'b0; i_de = 1'b1;
  endtask

  task automatic px(input logic [11:0] h, v, input logic [23:0] rgb, input logic de);
    i_hcount = h; i_vcount = v; i_rgb = rgb; i_de = de;
    @(posedge pixelclk);
    @(posedge pixelclk); #1;
  endtask

  initial begin
    reset = 1'b1; i_rgb = 24'h123456; i_hsync = 1'b1; i_vsync = 1'b0; i_de = 1'b1;
    i_hcount = '0; i_vcount = '0; cfg_we = 1'b0;
    cfg_set(3'd0, 1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 24'h0, 1'b0);

    repeat (3) @(posedge pixelclk);
    #1;
    chk("rst_rgb", {8'b0, o_rgb}, 32'h0);
    chk("rst_hsync", {31'b0, o_hsync}, 32'h0);
    chk("rst_vsync", {31'b0, o_vsync}, 32'h0);
    chk("rst_de", {31'b0, o_de}, 32'h0);
    chk("rst_frame", {24'b0, o_frame}, 32'h0);

    reset = 1'b0; i_rgb = 24'hABCDEF;
    @(posedge pixelclk); #1;
    chk("lat_cycle1", {8'b0, o_rgb}, 32'h0);
    @(posedge pixelclk); #1;
    chk("lat_cycle2", {8'b0, o_rgb}, 32'hABCDEF);
    chk("hsync_dly", {31'b0, o_hsync}, 32'h1);
    chk("de_dly", {31'b0, o_de}, 32'h1);
    i_hsync = 1'b0;

    cfg_wr(3'd0, 1'b1, 12'd10, 12'd20, 12'd5, 12'd8, 24'hFF0000, 1'b0);
    vs();

    t1[0] = '{12'd9,  12'd6,  24'h00AA55, 1'b1, 24'hFF0000};
    t1[1] = '{12'd21, 12'd6,  24'h00AA55, 1'b1, 24'hFF0000};
    t1[2] = '{12'd15, 12'd4,  24'h00AA55, 1'b1, 24'hFF0000};
    t1[3] = '{12'd8,  12'd6,  24'h00AA55, 1'b1, 24'h00AA55};
    t1[4] = '{12'd11, 12'd6,  24'h00AA55, 1'b1, 24'h00AA55};
    t1[5] = '{12'd10, 12'd5,  24'h00AA55, 1'b1, 24'hFF0000};
    t1[6] = '{12'd22, 12'd6,  24'h00AA55, 1'b1, 24'h00AA55};
    t1[7] = '{12'd15, 12'd9,  24'h00AA55, 1'b1, 24'hFF0000};
    t1[8] = '{12'd15, 12'd10, 24'h00AA55, 1'b1, 24'h00AA55};
    t1[9] = '{12'd9,  12'd6,  24'h00AA55, 1'b0, 24'h00AA55};
    for (int i = 0; i < 10; i++) begin
      px(t1[i].h, t1[i].v, t1[i].rgb, t1[i].de);
      chk($sformatf("box0_vec%0d", i), {8'b0, o_rgb}, {8'b0, t1[i].exp});
    end

    cfg_wr(3'd1, 1'b1, 12'd10, 12'd30, 12'd5, 12'd12, 24'h00FF00, 1'b0);
    px(12'd30, 12'd9, 24'h00AA55, 1'b1);
    chk("box1_not_yet", {8'b0, o_rgb}, 32'h00AA55);
    cfg_set(3'd2, 1'b1, 12'd100, 12'd110, 12'd50, 12'd60, 24'h0000FF, 1'b0);
    cfg_we = 1'b1;
    vs();
    px(12'd30, 12'd9, 24'h00AA55, 1'b1);
    chk("box1_active", {8'b0, o_rgb}, 32'h00FF00);
    px(12'd10, 12'd5, 24'h00AA55, 1'b1);
    chk("overlap_prio", {8'b0, o_rgb}, 32'hFF0000);
    px(12'd10, 12'd10, 24'h00AA55, 1'b1);
    chk("box1_only", {8'b0, o_rgb}, 32'h00FF00);
    px(12'd100, 12'd55, 24'h00AA55, 1'b1);
    chk("commit_cycle_wr_late", {8'b0, o_rgb}, 32'h00AA55);
    vs();
    px(12'd100, 12'd55, 24'h00AA55, 1'b1);
    chk("commit_cycle_wr_next", {8'b0, o_rgb}, 32'h0000FF);

    cfg_wr(3'd3, 1'b1, 12'd30, 12'd20, 12'd0, 12'd100, 24'h123456, 1'b0);
    cfg_wr(3'd5, 1'b1, 12'd300, 12'd310, 12'd300, 12'd310, 24'h777777, 1'b0);
    vs();
    px(12'd30, 12'd50, 24'h00AA55, 1'b1);
    chk("inverted_box_hl", {8'b0, o_rgb}, 32'h00AA55);
    px(12'd20, 12'd50, 24'h00AA55, 1'b1);
    chk("inverted_box_hr", {8'b0, o_rgb}, 32'h00AA55);
    px(12'd300, 12'd305, 24'h00AA55, 1'b1);
    chk("idx_oob_ignored", {8'b0, o_rgb}, 32'h00AA55);
    px(12'd30, 12'd9, 24'h00AA55, 1'b1);
    chk("idx_oob_no_alias", {8'b0, o_rgb}, 32'h00FF00);

    cfg_wr(3'd3, 1'b1, 12'd0, 12'd5, 12'd200, 12'd210, 24'h0F0F0F, 1'b0);
    vs();
    px(12'd4095, 12'd205, 24'h00AA55, 1'b1);
    chk("nowrap_lw2", {8'b0, o_rgb}, 32'h00AA55);
    chk("nowrap_lw4", {8'b0, o_rgb4}, 32'h00AA55);
    px(12'd0, 12'd205, 24'h00AA55, 1'b1);
    chk("clamp_edge_lw4", {8'b0, o_rgb4}, 32'h0F0F0F);
    px(12'd6, 12'd205, 24'h00AA55, 1'b1);
    chk("thick_lw2_in", {8'b0, o_rgb}, 32'h0F0F0F);
    px(12'd8, 12'd205, 24'h00AA55, 1'b1);
    chk("thick_lw2_out", {8'b0, o_rgb}, 32'h00AA55);
    chk("thick_lw4_in", {8'b0, o_rgb4}, 32'h0F0F0F);
    chk("de_lw4", {31'b0, o_de4}, 32'h1);

`ifdef DISPLAY_BOX_OVERLAY_FILL_EN
    cfg_wr(3'd2, 1'b1, 12'd100, 12'd110, 12'd50, 12'd60, 24'hFF00FE, 1'b1);
    vs();
    px(12'd105, 12'd55, 24'h000000, 1'b1);
    chk("fill_blend_black", {8'b0, o_rgb}, 32'h7F007F);
    px(12'd105, 12'd55, 24'hFFFFFF, 1'b1);
    chk("fill_blend_white", {8'b0, o_rgb}, 32'hFE7FFE);
    px(12'd100, 12'd55, 24'h000000, 1'b1);
    chk("fill_edge_wins", {8'b0, o_rgb}, 32'hFF00FE);
    px(12'd15, 12'd6, 24'h000000, 1'b1);
    chk("no_fill_interior", {8'b0, o_rgb}, 32'h000000);
`endif

    reset = 1'b1; i_rgb = 24'h00AA55; i_de = 1'b1;
    @(posedge pixelclk); #1;
    chk("midrst_rgb", {8'b0, o_rgb}, 32'h0);
    chk("midrst_frame", {24'b0, o_frame}, 32'h0);
    chk("midrst_de", {31'b0, o_de}, 32'h0);
    reset = 1'b0;
    exp_frame = 0;
    px(12'd9, 12'd6, 24'h00AA55, 1'b1);
    chk("midrst_box_disabled", {8'b0, o_rgb}, 32'h00AA55);
    vs();
    px(12'd9, 12'd6, 24'h00AA55, 1'b1);
    chk("midrst_shadow_cleared", {8'b0, o_rgb}, 32'h00AA55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
